dff_bank_arbiter: RTL and testbench
===================================

# dff_bank_arbiter

Round-robin arbiter that shares one WIDTH-bit D-flip-flop storage register among N requesters. Each cycle it picks at most one requester, registers a one-hot grant, and loads that requester's data into the shared register Q. A requester may assert lock to keep ownership for a bounded burst of consecutive writes. It sits between several producer blocks and a single shared state register, acting as the sequencer for that register.

## Interface
- WIDTH, 8, data width of the shared register
- N, 4, number of requesters (2..8)
- MAX_HOLD, 4, maximum consecutive cycles one locked owner keeps the grant (1..16)

- clk  input  1  rising-edge clock, the only clock
- rst  input  1  synchronous, active-high reset
- req  input  N  per-requester write request
- lock  input  N  per-requester burst-hold request; only meaningful together with the same bit of req
- wdata  input  N*WIDTH  requester data; requester i occupies bits [i*WIDTH +: WIDTH]
- gnt  output  N  registered one-hot grant; all-zero when idle
- owner  output  clog2(N)  index of the current grantee; holds its last value when idle
- valid  output  1  high in any cycle in which Q was loaded on the preceding edge
- Q  output  WIDTH  shared register contents

## Operation
- Internal state:
  - rr_ptr (clog2(N) bits): highest-priority index.
  - hold_cnt (clog2(MAX_HOLD)+1 bits).
  - FSM with states IDLE and OWN.
- Arbitration function, evaluated on each rising edge: scan req starting at rr_ptr, wrapping modulo N. The first set bit is the winner.
- IDLE:
  - req == 0: stay in IDLE. gnt <= 0, valid <= 0, Q holds.
  - Otherwise: move to OWN. gnt <= onehot(winner), owner <= winner, Q <= wdata[winner], valid <= 1, hold_cnt <= 0.
- OWN, with o = owner:
  - Continue condition: req[o] && lock[o] && hold_cnt < MAX_HOLD-1.
    - Stay with o. Q <= wdata[o], valid <= 1, hold_cnt <= hold_cnt+1. rr_ptr is unchanged.
  - Otherwise, release:
    - rr_ptr <= (o+1) mod N.
    - Re-arbitrate in the same edge, scanning from (o+1) mod N. o is eligible, but is scanned last.
    - If there is a winner: stay in OWN with the new owner, load Q, valid <= 1, hold_cnt <= 0. There is no idle bubble.
    - If req == 0: go to IDLE, gnt <= 0, valid <= 0.
- IDLE to OWN does not update rr_ptr. rr_ptr advances only on release.
- Requester without lock gets exactly one write per grant.
- Fairness: each requester with req held continuously is granted within N-1 grant periods, each at most MAX_HOLD cycles.
- lock without req is ignored.
- wdata is sampled only on edges where the corresponding gnt becomes or stays set.
- Reset values: gnt=0, owner=0, valid=0, Q=0, rr_ptr=0, hold_cnt=0, state=IDLE.
- rst has priority over every other input, including mid-burst. The cycle after reset deasserts behaves as IDLE with rr_ptr=0.

## Timing
- All outputs are registered and change only on rising clk.
- Latency from req asserting to gnt/Q/valid updating is 1 edge. Q equals the winner's wdata sampled at that edge.
- Owner handover is edge-to-edge: gnt never has two bits set and never drops for a cycle between back-to-back owners.
- A locked burst produces exactly MAX_HOLD consecutive valid cycles. With MAX_HOLD=1, lock has no effect.
- If req[o] drops mid-burst, release happens on the next edge. The value of Q written on that edge comes from the new winner; if there is none, Q holds.

## Test plan
- **Reset:** drive rst=1 with req=4'b1111 for 3 cycles.
  - Required: gnt=0, valid=0, Q=0, owner=0 throughout.
  - Release rst. First grant is to requester 0.
- **Single request:** req=4'b0100, lock=0, wdata[2]=8'hA5.
  - Required: after 1 edge, gnt=4'b0100, Q=8'hA5, valid=1.
  - Each following edge re-grants requester 2, since it is the only requester.
  - Drop req: next edge gnt=0, valid=0, Q stays A5.
- **Round-robin:** req=4'b1111, lock=0, wdata[i]=i+1.
  - Required: owner sequence 0,1,2,3,0,…
  - Q sequence 1,2,3,4,1, one per cycle, with no idle cycles.
- **Locked burst:** MAX_HOLD=4, req=4'b0011, lock=4'b0001.
  - Required: gnt=4'b0001 for exactly 4 consecutive cycles, then 4'b0010 for 1 cycle, then back to 0 for 4 cycles.
- **Early release:** requester 1 is locked. Deassert req[1] after 2 of its cycles while req[3]=1.
  - Required: next edge gnt=4'b1000, Q=wdata[3], no gap in valid.
- **Reset mid-burst:** assert rst during hold_cnt=2 for requester 2.
  - Required: next edge all outputs are at reset values.
  - After release with req=4'b0100, grant restarts with hold_cnt=0 and rr_ptr=0.

Source files
------------

// File: rtl/dff_bank_arbiter_if.sv
// Requester-side bus for the shared-register arbiter: requests, lock, data in;
// one-hot grant, owner index, valid strobe and shared register contents out.
interface dff_bank_arbiter_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned OW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]       req;
  logic [N-1:0]       lock;
  logic [N*WIDTH-1:0] wdata;
  logic [N-1:0]       gnt;
  logic [OW-1:0]      owner;
  logic               valid;
  logic [WIDTH-1:0]   Q;

  modport master (output req, lock, wdata, input gnt, owner, valid, Q);
  modport slave  (input req, lock, wdata, output gnt, owner, valid, Q);
endinterface

// File: rtl/dff_bank_arbiter.sv
// Round-robin sequencer for a single shared WIDTH-bit register; a locked owner
// may hold the grant for up to MAX_HOLD consecutive writes.
module dff_bank_arbiter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 4
) (
  input logic               clk,
  input logic               rst,
  dff_bank_arbiter_if.slave bus
);
  localparam int unsigned OW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned HW = $clog2(MAX_HOLD) + 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t           state, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             valid_q, valid_d;
  logic [OW-1:0]    rr_q, rr_d;
  logic [HW-1:0]    hold_q, hold_d;

  logic [OW-1:0]    next_idx;
  logic [OW-1:0]    scan_start;
  logic [OW:0]      win;
  logic [OW-1:0]    win_idx;
  logic             win_found;
  logic             keep;

  // First set bit of r scanning upward from start with wrap; MSB flags a hit.
  function automatic logic [OW:0] pick(input logic [N-1:0] r, input logic [OW-1:0] start);
    logic [OW:0] res;
    int          idx;
    res = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % int'(N);
      if (r[idx]) res = {1'b1, OW'(idx)};
    end
    return res;
  endfunction

  assign next_idx   = (owner_q == OW'(N - 1)) ? '0 : OW'(owner_q + OW'(1));
  assign scan_start = (state == IDLE) ? rr_q : next_idx;
  assign win        = pick(bus.req, scan_start);
  assign win_found  = win[OW];
  assign win_idx    = win[OW-1:0];
  assign keep       = bus.req[owner_q] && bus.lock[owner_q] &&
                      (hold_q < HW'(MAX_HOLD - 1));

  always_comb begin
    state_d = state;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    q_d     = q_q;
    valid_d = 1'b0;
    rr_d    = rr_q;
    hold_d  = hold_q;

    case (state)
      IDLE: begin
        if (win_found) begin
          state_d = OWN;
          gnt_d   = N'(1) << win_idx;
          owner_d = win_idx;
          q_d     = bus.wdata[win_idx*WIDTH +: WIDTH];
          valid_d = 1'b1;
          hold_d  = '0;
        end else begin
          gnt_d = '0;
        end
      end
      OWN: begin
        if (keep) begin
          q_d     = bus.wdata[owner_q*WIDTH +: WIDTH];
          valid_d = 1'b1;
          hold_d  = HW'(hold_q + HW'(1));
        end else begin
          // Release: re-arbitrate from the slot after the owner, no idle bubble.
          rr_d = next_idx;
          if (win_found) begin
            gnt_d   = N'(1) << win_idx;
            owner_d = win_idx;
            q_d     = bus.wdata[win_idx*WIDTH +: WIDTH];
            valid_d = 1'b1;
            hold_d  = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      rr_q    <= '0;
      hold_q  <= '0;
    end else begin
      state   <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.owner = owner_q;
  assign bus.valid = valid_q;
  assign bus.Q     = q_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed self-checking bench for dff_bank_arbiter (N=4, WIDTH=8, MAX_HOLD=4).
module tb_dff_bank_arbiter;
  localparam int unsigned N        = 4;
  localparam int unsigned WIDTH    = 8;
  localparam int unsigned MAX_HOLD = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  dff_bank_arbiter_if #(.N(N), .WIDTH(WIDTH)) bus ();

  dff_bank_arbiter #(.WIDTH(WIDTH), .N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wd(input int i, input logic [7:0] v);
    bus.wdata[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [7:0] q,
                           input logic v);
    check({tag, "_gnt"},   32'(bus.gnt),   32'(g));
    check({tag, "_q"},     32'(bus.Q),     32'(q));
    check({tag, "_valid"}, 32'(bus.valid), 32'(v));
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    bus.req   = '0;
    bus.lock  = '0;
    bus.wdata = '0;

    // Reset held with all requests active
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) set_wd(i, 8'(i + 1));
    for (int c = 0; c < 3; c++) begin
      step();
      check_out("reset", 4'b0000, 8'h00, 1'b0);
      check("reset_owner", 32'(bus.owner), 32'd0);
    end

    // First grant after reset goes to requester 0, then round-robin
    rst = 1'b0;
    step();
    check_out("first", 4'b0001, 8'h01, 1'b1);
    check("first_owner", 32'(bus.owner), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("rr_owner", 32'(bus.owner), 32'((k + 1) % 4));
      check("rr_q", 32'(bus.Q), 32'(((k + 1) % 4) + 1));
      check("rr_valid", 32'(bus.valid), 32'd1);
    end
    bus.req = 4'b0000;
    step();
    check_out("rr_idle", 4'b0000, 8'h01, 1'b0);

    // Single requester re-granted every edge
    bus.req = 4'b0100;
    set_wd(2, 8'hA5);
    for (int c = 0; c < 3; c++) begin
      step();
      check_out("single", 4'b0100, 8'hA5, 1'b1);
    end
    bus.req = 4'b0000;
    step();
    check_out("single_drop", 4'b0000, 8'hA5, 1'b0);

    // Locked burst: 4 cycles of req 0, one of req 1, back to req 0
    set_wd(0, 8'h10);
    set_wd(1, 8'h20);
    bus.req  = 4'b0011;
    bus.lock = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      step();
      check_out("burst0", 4'b0001, 8'h10, 1'b1);
    end
    step();
    check_out("burst1", 4'b0010, 8'h20, 1'b1);
    for (int c = 0; c < 4; c++) begin
      step();
      check_out("burst0b", 4'b0001, 8'h10, 1'b1);
    end
    bus.req  = 4'b0000;
    bus.lock = 4'b0000;
    step();
    check_out("burst_idle", 4'b0000, 8'h10, 1'b0);

    // Early release: locked req 1 drops after 2 cycles, req 3 takes over
    set_wd(1, 8'h21);
    set_wd(3, 8'h43);
    bus.req  = 4'b1010;
    bus.lock = 4'b0010;
    for (int c = 0; c < 2; c++) begin
      step();
      check_out("early1", 4'b0010, 8'h21, 1'b1);
    end
    bus.req = 4'b1000;
    step();
    check_out("early3", 4'b1000, 8'h43, 1'b1);
    bus.req  = 4'b0000;
    bus.lock = 4'b0000;
    step();
    check_out("early_idle", 4'b0000, 8'h43, 1'b0);

    // Reset mid-burst at hold_cnt=2 for requester 2
    set_wd(2, 8'h5C);
    set_wd(3, 8'h3D);
    bus.req  = 4'b0100;
    bus.lock = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      step();
      check_out("pre_rst", 4'b0100, 8'h5C, 1'b1);
    end
    rst = 1'b1;
    step();
    check_out("mid_rst", 4'b0000, 8'h00, 1'b0);
    check("mid_rst_owner", 32'(bus.owner), 32'd0);
    rst      = 1'b0;
    bus.req  = 4'b1100;
    for (int c = 0; c < 4; c++) begin
      step();
      check_out("post_rst2", 4'b0100, 8'h5C, 1'b1);
      check("post_rst_owner", 32'(bus.owner), 32'd2);
    end
    step();
    check_out("post_rst3", 4'b1000, 8'h3D, 1'b1);
    check("post_rst3_owner", 32'(bus.owner), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
